// File: rtl/multiples_sum_pkg.sv
// Shared types and default widths for the multiples-sum coprocessor.
package multiples_sum_pkg;

  localparam int unsigned N_W_DEF   = 16;
  localparam int unsigned ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } stateT;

endpackage

// File: rtl/multiples_sum_unit_wrap_counter.sv
// Modulo counter running 1..modulus and wrapping back to 1; at_mod flags the
// candidate that is an exact multiple of the modulus.
module mod_wrap_counter
  import multiples_sum_pkg::*;
#(
  parameter int unsigned N_W = N_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           en,
  input  logic [N_W-1:0] modulus,
  output logic [N_W-1:0] count,
  output logic           at_mod
);

  assign at_mod = (count == modulus);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= N_W'(1);
    end else if (en) begin
      count <= at_mod ? N_W'(1) : count + 1'b1;
    end
  end

endmodule

// File: rtl/multiples_sum_unit.sv
// Start-triggered coprocessor summing every k in 1..L divisible by div_a or
// div_b, one candidate per cycle, with sticky overflow and divisor-zero error.
module multiples_sum_unit
  import multiples_sum_pkg::*;
#(
  parameter int unsigned N_W   = N_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic [N_W-1:0]   div_a,
  input  logic [N_W-1:0]   div_b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             overflow,
  output logic             err
);

  // Sum is formed wide enough for both operands so any carry past ACC_W is seen
  localparam int unsigned SUM_W = ((ACC_W > N_W) ? ACC_W : N_W) + 1;

  stateT state, stateNext;

  logic [N_W-1:0]   lReg, divAReg, divBReg, kReg, bound;
  logic [N_W-1:0]   countA, countB;
  logic [ACC_W-1:0] acc;
  logic             ovfReg, errReg;
  logic             cntLoad, cntEn, atA, atB, hit, divZero, lastK;
  logic [SUM_W-1:0] sumWide;

  mod_wrap_counter #(.N_W(N_W)) uCntA (
    .clk(clk), .rst_n(rst_n), .load(cntLoad), .en(cntEn),
    .modulus(divAReg), .count(countA), .at_mod(atA)
  );

  mod_wrap_counter #(.N_W(N_W)) uCntB (
    .clk(clk), .rst_n(rst_n), .load(cntLoad), .en(cntEn),
    .modulus(divBReg), .count(countB), .at_mod(atB)
  );

  always_comb begin
    if (mode) begin
      bound = n;
    end else if (n == '0) begin
      bound = '0;
    end else begin
      bound = n - 1'b1;
    end
  end

  assign divZero = (divAReg == '0) || (divBReg == '0);
  assign hit     = atA | atB;
  assign lastK   = (kReg == lReg);
  assign sumWide = SUM_W'(acc) + SUM_W'(kReg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntLoad   = 1'b0;
    cntEn     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (divZero || (lReg == '0)) begin
          stateNext = DONE;
        end else begin
          cntLoad   = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        cntEn = 1'b1;
        if (lastK) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lReg     <= '0;
      divAReg  <= '0;
      divBReg  <= '0;
      kReg     <= '0;
      acc      <= '0;
      ovfReg   <= 1'b0;
      errReg   <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divAReg <= div_a;
            divBReg <= div_b;
            lReg    <= bound;
          end
        end
        CHECK: begin
          acc    <= '0;
          ovfReg <= 1'b0;
          errReg <= divZero;
          kReg   <= N_W'(1);
        end
        RUN: begin
          if (hit) begin
            acc <= sumWide[ACC_W-1:0];
            if (|sumWide[SUM_W-1:ACC_W]) ovfReg <= 1'b1;
          end
          if (!lastK) kReg <= kReg + 1'b1;
        end
        DONE: begin
          result   <= acc;
          overflow <= ovfReg;
          err      <= errReg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiples_sum_unit.sv
// Bench for multiples_sum_unit: a 32-bit and an 8-bit accumulator instance
// checked against an arithmetic reference model.
module tb_multiples_sum_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startW, startN;
  logic [15:0] nIn, aIn, bIn;
  logic        modeIn;
  logic        busyW, doneW, ovfW, errW;
  logic [31:0] resultW;
  logic        busyN, doneN, ovfN, errN;
  logic [7:0]  resultN;

  int checks = 0;
  int errors = 0;

  multiples_sum_unit #(.N_W(16), .ACC_W(32)) dutW (
    .clk(clk), .rst_n(rst_n), .start(startW), .n(nIn), .div_a(aIn),
    .div_b(bIn), .mode(modeIn), .busy(busyW), .done(doneW),
    .result(resultW), .overflow(ovfW), .err(errW)
  );

  multiples_sum_unit #(.N_W(16), .ACC_W(8)) dutN (
    .clk(clk), .rst_n(rst_n), .start(startN), .n(nIn), .div_a(aIn),
    .div_b(bIn), .mode(modeIn), .busy(busyN), .done(doneN),
    .result(resultN), .overflow(ovfN), .err(errN)
  );

  always #5 clk = ~clk;

  task automatic model(input int unsigned nv, input int unsigned av,
                       input int unsigned bv, input bit mv,
                       input int unsigned accW,
                       output longint unsigned expRes, output bit expOvf,
                       output bit expErr, output int expDone);
    longint unsigned lim, total;
    lim    = mv ? nv : ((nv == 0) ? 0 : nv - 1);
    total  = 0;
    expErr = (av == 0) || (bv == 0);
    if (!expErr)
      for (longint unsigned k = 1; k <= lim; k++)
        if ((k % av == 0) || (k % bv == 0)) total += k;
    expOvf  = total >= (64'd1 << accW);
    expRes  = total & ((64'd1 << accW) - 1);
    expDone = (expErr || lim == 0) ? 2 : int'(lim) + 2;
  endtask

  // Launches one operation and observes it; cycle 0 is the accepting cycle.
  task automatic do_op(input bit sel, input int unsigned nv, input int unsigned av,
                       input int unsigned bv, input bit mv, input bit poke,
                       output int doneCyc, output int doneCnt, output bit busyOk,
                       output logic [31:0] res, output logic ov, output logic er);
    int cyc;
    logic curDone, curBusy;
    res = 'x; ov = 1'bx; er = 1'bx;
    @(negedge clk);
    nIn = nv[15:0]; aIn = av[15:0]; bIn = bv[15:0]; modeIn = mv;
    if (sel) startN = 1'b1; else startW = 1'b1;
    @(posedge clk); #1;
    startW = 1'b0; startN = 1'b0;
    cyc = 1; doneCyc = -1; doneCnt = 0;
    busyOk = ((sel ? busyN : busyW) === 1'b1);
    while (cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc >= 3 && cyc <= 5) begin
        nIn = 16'd4; aIn = 16'd1; bIn = 16'd2;
        if (sel) startN = 1'b1; else startW = 1'b1;
      end else begin
        startW = 1'b0; startN = 1'b0;
      end
      curDone = sel ? doneN : doneW;
      curBusy = sel ? busyN : busyW;
      if (curDone === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
        busyOk &= (curBusy === 1'b0);
      end else if (doneCyc < 0) begin
        busyOk &= (curBusy === 1'b1);
      end else begin
        busyOk &= (curBusy === 1'b0);
      end
      if (doneCyc >= 0 && cyc == doneCyc + 1) begin
        res = sel ? {24'd0, resultN} : resultW;
        ov  = sel ? ovfN : ovfW;
        er  = sel ? errN : errW;
      end
      if (doneCyc >= 0 && cyc >= doneCyc + 3) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; startW = 1'b0; startN = 1'b0;
    nIn = '0; aIn = '0; bIn = '0; modeIn = 1'b0;
    #12;
    checks++;
    if ({busyW, doneW, ovfW, errW} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl_w: got %b expected 0000", {busyW, doneW, ovfW, errW});
    end
    checks++;
    if (resultW !== 32'd0) begin
      errors++; $display("FAIL reset_result_w: got %0d expected 0", resultW);
    end
    checks++;
    if ({busyN, doneN, ovfN, errN, resultN} !== 12'd0) begin
      errors++; $display("FAIL reset_n8: got %b expected 0", {busyN, doneN, ovfN, errN, resultN});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int dc, cnt; bit bok; logic [31:0] r; logic o, e;
    do_op(1'b0, 10, 3, 5, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 11", dc); end
    checks++;
    if (r !== 32'd23) begin errors++; $display("FAIL basic_result: got %0d expected 23", r); end
    checks++;
    if ({o, e} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {o, e}); end
    checks++;
    if (!bok) begin errors++; $display("FAIL basic_busy: got mismatch expected busy exactly cycles 1-10"); end
    do_op(1'b0, 10, 3, 5, 1'b1, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (dc !== 12) begin errors++; $display("FAIL incl_done_cycle: got %0d expected 12", dc); end
    checks++;
    if (r !== 32'd33) begin errors++; $display("FAIL incl_result: got %0d expected 33", r); end
  endtask

  task automatic test_sequence;
    int dc, cnt; bit bok; logic [31:0] r; logic o, e;
    do_op(1'b0, 16, 3, 5, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (r !== 32'd60) begin errors++; $display("FAIL seq16_result: got %0d expected 60", r); end
    do_op(1'b0, 10, 3, 3, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (r !== 32'd18) begin errors++; $display("FAIL same_div_result: got %0d expected 18", r); end
    do_op(1'b0, 1, 3, 5, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL l0_result: got %0d expected 0", r); end
    checks++;
    if (dc !== 2) begin errors++; $display("FAIL l0_done_cycle: got %0d expected 2", dc); end
  endtask

  task automatic test_error;
    int dc, cnt; bit bok; logic [31:0] r; logic o, e;
    do_op(1'b0, 100, 0, 5, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", e); end
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL err_result: got %0d expected 0", r); end
    checks++;
    if (dc !== 2) begin errors++; $display("FAIL err_done_cycle: got %0d expected 2", dc); end
    do_op(1'b0, 10, 3, 5, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if ({e, r} !== {1'b0, 32'd23}) begin
      errors++; $display("FAIL err_clear: got err=%b result=%0d expected err=0 result=23", e, r);
    end
  endtask

  task automatic test_overflow;
    int dc, cnt; bit bok; logic [31:0] r; logic o, e;
    do_op(1'b1, 30, 1, 1, 1'b0, 1'b0, dc, cnt, bok, r, o, e);
    checks++;
    if (r !== 32'd179) begin errors++; $display("FAIL ovf_result: got %0d expected 179", r); end
    checks++;
    if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", o); end
    checks++;
    if (dc !== 31) begin errors++; $display("FAIL ovf_done_cycle: got %0d expected 31", dc); end
  endtask

  task automatic test_reset_mid_run;
    int dc, cnt; bit bok; logic [31:0] r; logic o, e;
    @(negedge clk);
    nIn = 16'd1000; aIn = 16'd3; bIn = 16'd5; modeIn = 1'b0; startW = 1'b1;
    @(posedge clk); #1;
    startW = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    checks++;
    if (busyW !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", busyW); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busyW, doneW, ovfW, errW, resultW} !== 36'd0) begin
      errors++; $display("FAIL midrun_reset_w: got busy=%b done=%b ovf=%b err=%b result=%0d expected all 0",
                         busyW, doneW, ovfW, errW, resultW);
    end
    checks++;
    if ({ovfN, resultN} !== 9'd0) begin
      errors++; $display("FAIL midrun_reset_n8: got ovf=%b result=%0d expected 0", ovfN, resultN);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 10, 3, 5, 1'b0, 1'b1, dc, cnt, bok, r, o, e);
    checks++;
    if (r !== 32'd23) begin errors++; $display("FAIL after_reset_result: got %0d expected 23", r); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL busy_start_ignored: got %0d done pulses expected 1", cnt); end
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 11", dc); end
  endtask

  task automatic test_random;
    int dc, cnt, expDone; bit bok, expOvf, expErr; logic [31:0] r; logic o, e;
    longint unsigned expRes;
    int unsigned nv, av, bv; bit mv, sel;
    for (int i = 0; i < 24; i++) begin
      sel = (i >= 16);
      nv  = sel ? $urandom_range(0, 60) : $urandom_range(0, 150);
      av  = sel ? $urandom_range(1, 4) : $urandom_range(0, 9);
      bv  = sel ? $urandom_range(1, 4) : $urandom_range(0, 12);
      mv  = 1'($urandom);
      model(nv, av, bv, mv, sel ? 8 : 32, expRes, expOvf, expErr, expDone);
      do_op(sel, nv, av, bv, mv, 1'b0, dc, cnt, bok, r, o, e);
      checks++;
      if (r !== expRes[31:0] || o !== expOvf || e !== expErr) begin
        errors++;
        $display("FAIL rand%0d_outputs (n=%0d a=%0d b=%0d mode=%0d w=%0d): got res=%0d ovf=%b err=%b expected res=%0d ovf=%b err=%b",
                 i, nv, av, bv, mv, sel ? 8 : 32, r, o, e, expRes, expOvf, expErr);
      end
      checks++;
      if (dc !== expDone || cnt !== 1 || !bok) begin
        errors++;
        $display("FAIL rand%0d_timing: got done_cycle=%0d pulses=%0d busy_ok=%b expected %0d 1 1",
                 i, dc, cnt, bok, expDone);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_error();
    test_overflow();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiples_sum_unit.md
# multiples_sum_unit

- Iterative multicycle unit: sums every integer k in 1..L divisible by `div_a` or `div_b`.
- L is `n-1` (exclusive mode) or `n` (inclusive mode).
- Parametrised successor of the fixed 16-bit "multiples of 3 or 5" FSM+datapath calculator: runtime divisors, inclusive/exclusive bound, async reset, busy/done handshake, error and overflow reporting.
- Sits behind the control FSM as a start-triggered coprocessor; result held until the next completed operation.

## Interface
- `N_W`, default 16: width of `n`, divisors and iteration counter.
- `ACC_W`, default 32: width of the accumulator and `result`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `n`  in  N_W  bound operand; latched on accepted start.
- `div_a`  in  N_W  first divisor; latched on accepted start.
- `div_b`  in  N_W  second divisor; latched on accepted start.
- `mode`  in  1  0: L = n-1 (n=0 gives L=0); 1: L = n.
- `busy`  out  1  high in CHECK and RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `result`  out  ACC_W  sum modulo 2^ACC_W; holds its value between completions.
- `overflow`  out  1  set if any accumulation carried out of ACC_W; valid with `done`, held like `result`.
- `err`  out  1  set if a latched divisor was 0; valid with `done`, held.

## Operation
- States: IDLE, CHECK, RUN, DONE.
- IDLE:
  - On `start`=1: latch `n`, `div_a`, `div_b`, `mode`; compute L; go to CHECK.
  - Otherwise stay in IDLE.
- CHECK:
  - If either divisor is 0: err_next=1, acc=0, go to DONE.
  - Else if L=0: acc=0, go to DONE.
  - Else: k=1, ca=1, cb=1, acc=0, ovf=0, go to RUN.
- RUN, one candidate per cycle:
  - hit = (ca==div_a) | (cb==div_b).
  - If hit: acc += zero-extended k. Carry out of ACC_W sets sticky ovf; acc wraps.
  - ca wraps to 1 after reaching div_a, else increments; cb likewise with div_b.
  - If k==L: go to DONE. Else k++.
- DONE:
  - Register acc/ovf/err into `result`/`overflow`/`err`.
  - `done`=1 for this cycle; return to IDLE.
- `start` during CHECK/RUN/DONE is ignored; there is no queueing.
- div_a==div_b: each k is added at most once.
- Divisor 1: every k hits.
- Divisor > L: that divisor never hits.
- Internal arithmetic: k and counters are N_W bits, so L ≤ 2^N_W-1 never wraps k.
- Reset asserted at any time, mid-RUN included:
  - Immediately: state=IDLE; `busy`, `done`, `err`, `overflow` = 0; `result` = 0.
  - The interrupted operation is discarded.

## Timing
- Cycle 0: start accepted in IDLE. Cycle 1: CHECK. Cycles 2..L+1: RUN, processing k=1..L. Cycle L+2: DONE with `done`=1.
- `result` updates on the edge entering the cycle after DONE, i.e. it is valid from cycle L+3 on. Same for `overflow` and `err`.
- Error or L=0: DONE at cycle 2, so `done`=1 at cycle 2.
- Earliest next accepted start: the cycle after DONE.
- `busy` is registered-state decoded: high exactly in CHECK and RUN.
- Reset values: `busy`=0, `done`=0, `result`=0, `overflow`=0, `err`=0.

## Structure
- Shared package `multiples_sum_pkg`:
  - state typedef (IDLE, CHECK, RUN, DONE; 2-bit encoding);
  - default widths `N_W_DEF`=16 and `ACC_W_DEF`=32.
- Sub-module `mod_wrap_counter` (parameter N_W):
  - ports: clk, rst_n, load, en, modulus, count, at_mod;
  - counts 1..modulus and wraps to 1;
  - instantiated twice, for ca and cb.
- Top holds the FSM, k counter, accumulator with carry and output registers.

## Test plan
- n=10, a=3, b=5, mode=0 → `done` at cycle 11; result=23; overflow=0; err=0; busy high cycles 1–10.
- n=10, a=3, b=5, mode=1 → result=33, `done` at cycle 12.
- n=16, a=3, b=5, mode=0 → 60. Then n=10, a=b=3, mode=0 → 18 (no double count). Then n=1, mode=0 → result=0, `done` at cycle 2.
- div_a=0, n=100 → err=1, result=0, `done` at cycle 2. Follow with a valid op → err returns to 0.
- ACC_W=8 instance: n=30, a=b=1, mode=0 → true sum 435; result=179 with overflow=1.
- Reset mid-RUN (n=1000, cycle 50) → all outputs 0 immediately. New start with n=10, a=3, b=5, mode=0 → result=23. `start` pulsed while busy → ignored; a single `done` only.
